// File: rtl/syn_fifo_pkg.sv
// ============================================================================
// Module   : syn_fifo_pkg
// Purpose  : Width helpers and error-flag type shared by the syn_fifo blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

package syn_fifo_pkg;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so the count can represent DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage

`default_nettype wire

// File: rtl/syn_fifo_mem.sv
// ============================================================================
// Module   : syn_fifo_mem
// Purpose  : DATA_WIDTH x DEPTH register array, sync write, async read.
// Revision : 1.0
// ============================================================================
`default_nettype none

module syn_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    // Storage is deliberately left out of reset.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/syn_fifo_param.sv
// ============================================================================
// Module   : syn_fifo_param
// Purpose  : Single-clock FIFO with occupancy count, threshold flags, sticky
//            errors; SYN_FIFO_FWFT_EN selects first-word-fall-through reads.
// Revision : 1.0
// ============================================================================
`default_nettype none

module syn_fifo_param
    import syn_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int C_PTR_W = ptr_width(DEPTH);
    localparam int C_CNT_W = cnt_width(DEPTH);

    logic [C_PTR_W-1:0]    r_w_ptr;
    logic [C_PTR_W-1:0]    r_r_ptr;
    logic [C_CNT_W-1:0]    r_count;
    err_flags_t            r_err;
    logic                  w_wa;
    logic                  w_ra;
    logic [DATA_WIDTH-1:0] w_rdata;

    // Flags come only from the registered count, keeping request inputs off
    // every output path.
    assign full         = (r_count == C_CNT_W'(DEPTH));
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= C_CNT_W'(AF_LEVEL));
    assign almost_empty = (r_count <= C_CNT_W'(AE_LEVEL));
    assign count        = r_count;
    assign overflow     = r_err.overflow;
    assign underflow    = r_err.underflow;

    assign w_wa = w_en && !full;
    assign w_ra = r_en && !empty;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_w_ptr <= '0;
            r_r_ptr <= '0;
            r_count <= '0;
        end else begin
            if (w_wa) begin
                r_w_ptr <= r_w_ptr + C_PTR_W'(1);
            end
            if (w_ra) begin
                r_r_ptr <= r_r_ptr + C_PTR_W'(1);
            end
            if (w_wa && !w_ra) begin
                r_count <= r_count + C_CNT_W'(1);
            end else if (!w_wa && w_ra) begin
                r_count <= r_count - C_CNT_W'(1);
            end
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_err <= '0;
        end else begin
            if (w_en && full) begin
                r_err.overflow <= 1'b1;
            end else if (err_clr) begin
                r_err.overflow <= 1'b0;
            end
            if (r_en && empty) begin
                r_err.underflow <= 1'b1;
            end else if (err_clr) begin
                r_err.underflow <= 1'b0;
            end
        end
    end

    syn_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (C_PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_wa),
        .waddr (r_w_ptr),
        .wdata (data_in),
        .raddr (r_r_ptr),
        .rdata (w_rdata)
    );

`ifdef SYN_FIFO_FWFT_EN
    assign data_out = empty ? '0 : w_rdata;
`else
    logic [DATA_WIDTH-1:0] r_data_out;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_data_out <= '0;
        end else if (w_ra) begin
            r_data_out <= w_rdata;
        end
    end

    assign data_out = r_data_out;
`endif

endmodule

`default_nettype wire

// File: tb/tb_syn_fifo_param.sv
// ============================================================================
// Module   : tb_syn_fifo_param
// Purpose  : Directed self-checking bench for syn_fifo_param (8x8, AF=6, AE=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_syn_fifo_param;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       w_en;
    logic [7:0] data_in;
    logic       r_en;
    logic       err_clr;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    syn_fifo_param #(
        .DATA_WIDTH (8),
        .DEPTH      (8),
        .AF_LEVEL   (6),
        .AE_LEVEL   (2)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .w_en         (w_en),
        .data_in      (data_in),
        .r_en         (r_en),
        .err_clr      (err_clr),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pop one word; FWFT shows it before the edge, standard mode after it.
    task automatic pop_check(input logic [7:0] exp);
`ifdef SYN_FIFO_FWFT_EN
        check("pop_data", data_out, exp);
        r_en = 1'b1;
        step();
        r_en = 1'b0;
`else
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        check("pop_data", data_out, exp);
`endif
    endtask

    initial begin
        logic [7:0] v;
        clr_n   = 1'b0;
        w_en    = 1'b0;
        data_in = 8'h00;
        r_en    = 1'b0;
        err_clr = 1'b0;
        step();
        step();

        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_ae", almost_empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        check("rst_dout", data_out, 0);
        clr_n = 1'b1;

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            w_en    = 1'b1;
            data_in = 8'(i);
            step();
            check("fill_count", count, i);
            check("fill_ae", almost_empty, (i <= 2));
            check("fill_af", almost_full, (i >= 6));
            check("fill_full", full, (i == 8));
            check("fill_empty", empty, 0);
        end
        check("fill_ovf", overflow, 0);

        // Write while full is dropped
        data_in = 8'hFF;
        step();
        w_en = 1'b0;
        check("ovf_count", count, 8);
        check("ovf_flag", overflow, 1);

        for (int i = 1; i <= 8; i++) begin
            pop_check(8'(i));
            check("drain_count", count, 8 - i);
        end
        check("drain_empty", empty, 1);
        check("drain_full", full, 0);

        // Underflow and err_clr
        r_en = 1'b1;
        step();
        r_en = 1'b0;
        check("unf_flag", underflow, 1);
        check("unf_ovf_sticky", overflow, 1);
        check("unf_count", count, 0);
`ifdef SYN_FIFO_FWFT_EN
        check("unf_dout", data_out, 8'h00);
`else
        check("unf_dout", data_out, 8'h08);
`endif
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr_unf", underflow, 0);
        check("clr_ovf", overflow, 0);
        err_clr = 1'b1;
        r_en    = 1'b1;
        step();
        r_en    = 1'b0;
        check("clr_vs_set", underflow, 1);
        step();
        err_clr = 1'b0;
        check("clr_again", underflow, 0);

        // Simultaneous write+read at count 4
        for (int i = 0; i < 4; i++) begin
            w_en    = 1'b1;
            data_in = 8'h10 + 8'(i);
            step();
        end
        check("sim4_pre", count, 4);
        data_in = 8'h14;
        pop_check(8'h10);
        check("sim4_count", count, 4);
        for (int i = 5; i <= 8; i++) begin
            data_in = 8'h10 + 8'(i);
            step();
        end
        check("simf_pre", count, 8);
        data_in = 8'h19;
        pop_check(8'h11);
        w_en = 1'b0;
        check("simf_count", count, 7);
        check("simf_ovf", overflow, 1);
        check("simf_full", full, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            pop_check(8'h10 + 8'(i));
        end
        check("simf_empty", empty, 1);

        // Interleaved pairs across pointer wrap
        for (int k = 0; k < 20; k++) begin
            v       = 8'h80 + 8'(k * 3);
            w_en    = 1'b1;
            data_in = v;
            step();
            w_en = 1'b0;
            check("wrap_cnt1", count, 1);
            pop_check(v);
            check("wrap_cnt0", count, 0);
        end

        // Asynchronous reset mid-burst
        for (int i = 0; i < 5; i++) begin
            w_en    = 1'b1;
            data_in = 8'h40 + 8'(i);
            step();
        end
        check("burst_count", count, 5);
        data_in = 8'h45;
        #2;
        clr_n = 1'b0;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_dout", data_out, 0);
        check("arst_ae", almost_empty, 1);
        check("arst_af", almost_full, 0);
        step();
        check("arst_hold", count, 0);
        clr_n   = 1'b1;
        data_in = 8'hA5;
        step();
        w_en = 1'b0;
        check("post_count", count, 1);
        check("post_empty", empty, 0);
        pop_check(8'hA5);
        check("post_drain", empty, 1);
        check("post_ovf", overflow, 0);
        check("post_unf", underflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/syn_fifo_param.md
# syn_fifo_param

Parametrised single-clock FIFO, the successor to the basic synchronous FIFO in the memory library. Adds full-depth utilisation via an occupancy counter, programmable almost-full and almost-empty thresholds, sticky overflow and underflow error flags, and an optional first-word-fall-through read mode. It sits between same-clock producer and consumer blocks that need rate decoupling and early back-pressure.

## Interface
- DATA_WIDTH, 8, width of data words; legal range is 1 or more.
- DEPTH, 8, number of entries; must be a power of two, 2 or more.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL; legal range 0..DEPTH-1.
- clk  in  1  the single clock; all logic samples on its rising edge.
- clr_n  in  1  reset; asynchronous assertion, active-low.
- w_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- r_en  in  1  read request (pop).
- err_clr  in  1  synchronous clear of overflow and underflow.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: a write was attempted while full.
- underflow  out  1  sticky flag: a read was attempted while empty.

## Operation
- Pointers w_ptr and r_ptr are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. All DEPTH entries are usable.
- Write accepted (wa) = w_en && !full. Read accepted (ra) = r_en && !empty. Acceptance is evaluated on the registered flags at the start of the cycle.
- On wa: mem[w_ptr] <= data_in and w_ptr increments. On ra: r_ptr increments.
- count update:
  - +1 on wa only.
  - -1 on ra only.
  - Unchanged when both are accepted, or when neither is.
- Rejected requests:
  - A write when full does not write, and the pointer does not move.
  - A read when empty leaves data_out unchanged.
- full, empty, almost_full and almost_empty are decoded combinationally from the registered count.
- Error flags:
  - overflow sets on w_en && full; underflow sets on r_en && empty.
  - Both hold until err_clr or reset.
  - If err_clr and a new error occur in the same cycle, the set wins.
- Reset (clr_n=0), at any time including mid-transfer:
  - Pointers, count, overflow, underflow and data_out go to 0; empty=1, almost_empty=1, full=0, almost_full=0.
  - Memory contents are not cleared.
  - Release is synchronous to clk; the first write can be accepted on the first edge after release.

## Timing
- Standard mode: data_out is a register loaded with mem[r_ptr] on ra and valid the cycle after the accepting edge (1-cycle read latency). It holds its value otherwise.
- Write to observable: a write accepted at edge N updates count and clears empty after edge N. A read can be accepted at edge N+1.
- Full to not-full: after a pop at edge N, full drops after edge N, and a write is accepted at edge N+1.
- No combinational path from w_en or r_en to any output.

## Configuration
- SYN_FIFO_FWFT_EN defined:
  - data_out = empty ? 0 : mem[r_ptr], combinational from registered state.
  - The head word is visible one cycle after the write that fills an empty FIFO.
  - r_en acknowledges (pops) the word currently shown; the next word appears after the edge.
- SYN_FIFO_FWFT_EN undefined: standard registered-read behaviour as described under Timing.
- Flags, count and error behaviour are identical in both modes.

## Structure
- Package syn_fifo_pkg holds:
  - the pointer-width and count-width helper constants/functions;
  - the error-flag typedef (overflow and underflow bits).
- Sub-module syn_fifo_mem: DATA_WIDTH x DEPTH register array with one synchronous write port and one asynchronous read port. Control, counter and flag logic stay in the top level.

## Test plan
All scenarios use DATA_WIDTH=8, DEPTH=8, AF_LEVEL=6, AE_LEVEL=2.
- Reset, then fill: write 0x01..0x08 -> count steps 1..8; almost_empty drops at count 3; almost_full rises at count 6; full at count 8; no overflow.
- Ninth write 0xFF while full -> it is dropped and overflow=1. Drain all 8 -> data 0x01..0x08 in order, with 1-cycle latency in standard mode and 0 in FWFT mode. Then empty=1.
- Read while empty -> underflow=1 and data_out unchanged. err_clr pulse -> underflow=0. err_clr together with a new empty read -> underflow stays 1.
- Simultaneous write and read at count 4 -> count stays 4. At full, simultaneous write and read -> only the read is accepted and count becomes 7.
- Wrap: 20 interleaved write/read pairs with a running pattern -> output order is exact across pointer wrap.
- Assert clr_n mid-burst at count 5, asynchronously between edges -> count=0, empty=1 and data_out=0 immediately. Next write 0xA5 then read -> 0xA5.
